// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//
// Data-memory access controller that sits between the CPU load/store stage and
// a synchronous single-port RAM. It accepts one byte/halfword/word load or
// store at a time and always drives word-aligned RAM cycles:
//   - loads read the word, pick the addressed lane and sign/zero-extend it;
//   - word stores write the store data directly;
//   - byte/half stores read the word, merge the new lane(s) in, then write the
//     merged word back (read-modify-write).
// Misaligned halfword/word accesses and the reserved size code finish with an
// error response and never touch the RAM.
//
// Parameter:
//   BIG_ENDIAN   1: byte offset 0 is bits [31:24]; 0: byte offset 0 is [7:0]
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   req          request valid, only looked at while busy is low
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr     byte address
//   req_wdata    store data, right-justified
//   busy         high whenever the controller is not idle
//   resp_valid   one-cycle completion pulse
//   resp_rdata   extended load data (0 after stores/errors), held between
//                responses
//   resp_err     qualifies resp_valid: misaligned access or reserved size
//   ram_cs       RAM chip select
//   ram_oe       RAM read enable
//   ram_we       RAM write enable
//   ram_addr     word-aligned latched address, 0 while idle
//   ram_din      word written to the RAM
//   ram_dout     RAM read data, valid the cycle after a cs&oe cycle
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Replace the 8-bit lane starting at bit 'sh' of 'word' with 'b'.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [4:0]  sh);
    logic [31:0] mask;
    mask = 32'h0000_00FF << sh;
    return (word & ~mask) | ({24'h00_0000, b} << sh);
  endfunction

  // Replace the 16-bit lane starting at bit 'sh' of 'word' with 'h'.
  function automatic logic [31:0] merge_half(input logic [31:0] word,
                                             input logic [15:0] h,
                                             input logic [4:0]  sh);
    logic [31:0] mask;
    mask = 32'h0000_FFFF << sh;
    return (word & ~mask) | ({16'h0000, h} << sh);
  endfunction

  state_t      r_state;
  state_t      w_next_state;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;     // only the low half is ever merged
  logic [31:0] r_rdata;
  logic [31:0] r_din;

  logic        w_req_err;
  logic [1:0]  w_byte_pos;
  logic        w_half_pos;
  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  // Classify the incoming request: reserved size or misaligned half/word.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_req_err = 1'b0;
      SZ_HALF: w_req_err = req_addr[0];
      SZ_WORD: w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  // Lane position inside the RAM word; in big-endian order offset 0 is the
  // most significant lane, so the position is the inverted offset.
  always_comb begin
    w_byte_pos = r_addr[1:0];
    w_half_pos = r_addr[1];
    if (BIG_ENDIAN) begin
      w_byte_pos = ~r_addr[1:0];
      w_half_pos = ~r_addr[1];
    end else begin
      w_byte_pos = r_addr[1:0];
      w_half_pos = r_addr[1];
    end
  end

  assign w_byte_sh = {w_byte_pos, 3'b000};
  assign w_half_sh = {w_half_pos, 4'b0000};
  assign w_lane_b  = ram_dout[w_byte_sh +: 8];
  assign w_lane_h  = ram_dout[w_half_sh +: 16];

  // Extend the selected load lane to 32 bits.
  always_comb begin
    w_load_ext = ram_dout;
    case (r_size)
      SZ_BYTE: begin
        if (r_unsigned) begin
          w_load_ext = {24'h00_0000, w_lane_b};
        end else begin
          w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
        end
      end
      SZ_HALF: begin
        if (r_unsigned) begin
          w_load_ext = {16'h0000, w_lane_h};
        end else begin
          w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
        end
      end
      default: w_load_ext = ram_dout;
    endcase
  end

  // Merge the latched store data into the word just read back.
  always_comb begin
    w_merged = ram_dout;
    case (r_size)
      SZ_BYTE: w_merged = merge_byte(ram_dout, r_wdata[7:0], w_byte_sh);
      SZ_HALF: w_merged = merge_half(ram_dout, r_wdata, w_half_sh);
      default: w_merged = ram_dout;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!req) begin
          w_next_state = S_IDLE;
        end else if (w_req_err) begin
          w_next_state = S_ERR;
        end else if (req_we && (req_size == SZ_WORD)) begin
          w_next_state = S_WR;
        end else begin
          w_next_state = S_RD;
        end
      end
      S_RD:      w_next_state = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_we) begin
          w_next_state = S_WR;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_WR:      w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      S_ERR:     w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch, load-data and write-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 16'h0000;
      r_rdata    <= 32'h0000_0000;
      r_din      <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata[15:0];
            // Word stores go straight to WR, so their write word is known now.
            if (req_we && (req_size == SZ_WORD)) begin
              r_din <= req_wdata;
            end
            // Error responses carry zero data.
            if (w_req_err) begin
              r_rdata <= 32'h0000_0000;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_we) begin
            r_din <= w_merged;
          end else begin
            r_rdata <= w_load_ext;
          end
        end
        // Stores complete with zero data; cleared here so it shows in DONE.
        S_WR: r_rdata <= 32'h0000_0000;
        default: begin
        end
      endcase
    end
  end

  // Moore output decode from the state register.
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_DONE) || (r_state == S_ERR);
  assign resp_err   = (r_state == S_ERR);
  assign ram_oe     = (r_state == S_RD);
  assign ram_we     = (r_state == S_WR);
  assign ram_cs     = (r_state == S_RD) || (r_state == S_WR);
  assign ram_addr   = busy ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
  assign ram_din    = r_din;
  assign resp_rdata = r_rdata;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller between the CPU load/store stage and the synchronous RAM (cs/oe/we/addr/din/dout interface).
- Accepts one byte/halfword/word load or store at a time.
- Drives word-aligned RAM cycles, sign- or zero-extends load data, and performs read-modify-write for sub-word stores.
- Reports busy for pipeline stall and a one-cycle completion pulse.

Parameters:
- BIG_ENDIAN, 1, 1: byte offset 0 maps to bits [31:24] (MIPS order); 0: byte offset 0 maps to bits [7:0].

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req  in  1  request valid; sampled only while busy=0
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- busy  out  1  high whenever FSM not in IDLE
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data, held until next resp_valid; 0 after stores
- resp_err  out  1  valid with resp_valid; misaligned or reserved size
- ram_cs  out  1  RAM chip select
- ram_oe  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- ram_addr  out  32  {req_addr[31:2],2'b00} of latched request
- ram_din  out  32  write word
- ram_dout  in  32  RAM read data, valid the cycle after a cs&oe cycle

Behaviour:
- Reset state: IDLE. All outputs 0: busy, resp_valid, resp_rdata, resp_err, ram_*.
  - Async assertion drops the RAM strobes immediately; the in-flight operation is abandoned with no response.
- States: IDLE, RD, RD_WAIT, WR, DONE, ERR. RAM strobes are decoded from the state register only (Moore outputs).
- IDLE: on req=1, latch the request, then check it:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
  - Word store -> WR.
  - Load or sub-word store -> RD.
  - req=0 stays in IDLE.
- RD: ram_cs=ram_oe=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: ram_dout is valid.
  - Load: extract the lane per size/offset/BIG_ENDIAN, extend, register into resp_rdata -> DONE.
  - Sub-word store: merge req_wdata into the selected lane(s) of ram_dout, register as ram_din -> WR.
- WR: ram_cs=ram_we=1, ram_oe=0 for exactly one cycle; ram_din stable -> DONE.
- DONE: resp_valid=1, resp_err=0 for one cycle -> IDLE.
- ERR: resp_valid=1, resp_err=1 for one cycle, no RAM strobe at any point -> IDLE.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
  - Error: 1 cycle.
- Handshake:
  - busy = (state != IDLE), asserted the cycle after acceptance.
  - req during busy is ignored; the requester holds req until it observes resp_valid.
  - A new req in the same cycle as resp_valid is not accepted (FSM is in DONE/ERR); it is accepted on the following edge.
  - Back-to-back throughput is therefore latency+1 cycles per access.
- Strobes:
  - ram_oe and ram_we are never high together.
  - ram_cs is high iff ram_oe or ram_we is high.
  - ram_addr holds the aligned latched address in every non-IDLE state and is 0 in IDLE.
- Extension: byte sign bit is lane bit 7; half sign bit is lane bit 15.
- Word store with size=10 writes req_wdata unmodified.

Test Plan:
- RAM[0x100]=0x11223344; load byte signed @0x101 -> one RD, one RD_WAIT; resp_valid 3 cycles after accept; resp_rdata=0x00000022, resp_err=0.
- RAM[0x104]=0x80FF7F01:
  - lb @0x104 -> 0xFFFFFF80.
  - lbu @0x104 -> 0x00000080.
  - lh @0x106 -> 0x00007F01.
  - lw @0x104 -> 0x80FF7F01.
- RAM[0x100]=0x11223344; sb 0x000000AB @0x102 -> strobe sequence cs&oe, idle, cs&we with ram_addr=0x100, ram_din=0x1122AB44; resp_valid at cycle 4; subsequent lw @0x100 returns 0x1122AB44.
- sw 0xDEADBEEF @0x101 and lh @0x103 -> resp_valid and resp_err=1 one cycle after accept; ram_cs never asserted; RAM contents unchanged.
- Hold req high across a word store -> exactly one accept, one WR cycle, busy high 2 cycles; second accept only after the DONE cycle.
- Assert rst mid-WR of an sb -> ram_we/ram_cs drop asynchronously, no resp_valid; after release busy=0 and a fresh lw completes normally.
